// File: rtl/pal_cfg_loader.sv
// pal_cfg_loader: streams a PAL configuration bitstream, delivered as bytes,
// MSB first onto the PAL's serial CFG input. It raises CFG_VALID once
// CFG_BITS bits have been shifted.
// Optional feature: define PAL_CFG_CRC_EN to accept a CRC-8 trailer byte
// (poly 0x07, init 0x00, MSB-first) after the payload. The load then ends in
// ERROR when the trailer does not match.
module pal_cfg_loader #(
  parameter int N        = 8,
  parameter int M        = 4,
  parameter int P        = 4,
  parameter int CFG_BITS = 2*N*P + P*M
) (
  input  logic       CLK,
  input  logic       RES_N,
  input  logic       START,
  input  logic [7:0] BYTE_IN,
  input  logic       BYTE_VALID,
  output logic       BYTE_READY,
  output logic       CFG_BIT,
  output logic       SHIFT_EN,
  output logic       BUSY,
  output logic       CFG_VALID,
  output logic       ERR
);

  // Sized so that the counter can hold CFG_BITS itself without wrapping.
  localparam int CW = $clog2(CFG_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_CHECK, S_DONE, S_ERROR
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            cfg_valid_q, cfg_valid_d;
  logic            byte_ready_q, byte_ready_d;
  logic            shift_en_q, shift_en_d;
  logic            cfg_bit_q, cfg_bit_d;
  logic            busy_q, busy_d;
  logic            last_bit;
`ifdef PAL_CFG_CRC_EN
  logic [7:0]      crc_q, crc_d;
  logic            err_q, err_d;
`endif

  // The byte ends after bit 7. It also ends early when the whole stream is
  // complete, so the unused LSBs of a final partial byte are dropped.
  assign last_bit = (bit_idx_q == 3'd7) || (count_q == CW'(CFG_BITS - 1));

  // Next-state logic and the next values of all outputs. Every output is
  // a flop, so the PAL never sees a combinational path from BYTE_IN or START.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    count_d      = count_q;
    bit_idx_d    = bit_idx_q;
    cfg_valid_d  = cfg_valid_q;
`ifdef PAL_CFG_CRC_EN
    crc_d        = crc_q;
    err_d        = err_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (START) begin
          state_d     = S_LOAD;
          cfg_valid_d = 1'b0;
          count_d     = '0;
`ifdef PAL_CFG_CRC_EN
          crc_d       = 8'h00;
          err_d       = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (BYTE_VALID) begin
          shreg_d   = BYTE_IN;
          bit_idx_d = 3'd0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_d   = {shreg_q[6:0], 1'b0};
        count_d   = count_q + CW'(1);
        bit_idx_d = bit_idx_q + 3'd1;
`ifdef PAL_CFG_CRC_EN
        crc_d     = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ shreg_q[7]) ? 8'h07 : 8'h00);
`endif
        if (last_bit) begin
          state_d = (count_q == CW'(CFG_BITS - 1)) ? S_CHECK : S_LOAD;
        end
      end
      S_CHECK: begin
`ifdef PAL_CFG_CRC_EN
        if (BYTE_VALID) begin
          if (BYTE_IN == crc_q) begin
            state_d     = S_DONE;
            cfg_valid_d = 1'b1;
          end else begin
            state_d     = S_ERROR;
            err_d       = 1'b1;
          end
        end
`else
        state_d     = S_DONE;
        cfg_valid_d = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase

`ifdef PAL_CFG_CRC_EN
    byte_ready_d = (state_d == S_LOAD) || (state_d == S_CHECK);
`else
    byte_ready_d = (state_d == S_LOAD);
`endif
    shift_en_d = (state_d == S_SHIFT);
    cfg_bit_d  = (state_d == S_SHIFT) ? shreg_d[7] : 1'b0;
    busy_d     = (state_d == S_LOAD) || (state_d == S_SHIFT) || (state_d == S_CHECK);
  end

  // State and output registers. The asynchronous reset drops every output
  // at once, even in the middle of a load.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      count_q      <= '0;
      bit_idx_q    <= '0;
      cfg_valid_q  <= 1'b0;
      byte_ready_q <= 1'b0;
      shift_en_q   <= 1'b0;
      cfg_bit_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef PAL_CFG_CRC_EN
      crc_q        <= 8'h00;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      count_q      <= count_d;
      bit_idx_q    <= bit_idx_d;
      cfg_valid_q  <= cfg_valid_d;
      byte_ready_q <= byte_ready_d;
      shift_en_q   <= shift_en_d;
      cfg_bit_q    <= cfg_bit_d;
      busy_q       <= busy_d;
`ifdef PAL_CFG_CRC_EN
      crc_q        <= crc_d;
      err_q        <= err_d;
`endif
    end
  end

  assign BYTE_READY = byte_ready_q;
  assign SHIFT_EN   = shift_en_q;
  assign CFG_BIT    = cfg_bit_q;
  assign BUSY       = busy_q;
  assign CFG_VALID  = cfg_valid_q;
`ifdef PAL_CFG_CRC_EN
  assign ERR        = err_q;
`else
  assign ERR        = 1'b0;
`endif

endmodule

// File: doc/pal_cfg_loader.md
PAL_CFG_LOADER -- requirements
Module: pal_cfg_loader

Interface
REQ-001 SHALL have parameter N, default 8, meaning the PAL input-variable count.
REQ-002 SHALL have parameter M, default 4, meaning the PAL output count.
REQ-003 SHALL have parameter P, default 4, meaning the PAL intermediate-stage count.
REQ-004 SHALL have parameter CFG_BITS, default 2*N*P+P*M (80), meaning the bitstream length in bits.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all flops use the rising edge.
REQ-006 SHALL have port RES_N, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port START, input, 1 bit: request a new load; sampled only in IDLE, DONE or ERROR.
REQ-008 SHALL have port BYTE_IN, input, 8 bits: bitstream byte, shifted MSB first.
REQ-009 SHALL have port BYTE_VALID, input, 1 bit: BYTE_IN is valid.
REQ-010 SHALL have port BYTE_READY, output, 1 bit: the loader accepts a byte this cycle.
REQ-011 SHALL have port CFG_BIT, output, 1 bit: serial config data to the PAL CFG input.
REQ-012 SHALL have port SHIFT_EN, output, 1 bit: the PAL shifts CFG_BIT on this cycle.
REQ-013 SHALL have port BUSY, output, 1 bit: a load is in progress.
REQ-014 SHALL have port CFG_VALID, output, 1 bit: level signal that the PAL holds a complete configuration.
REQ-015 SHALL have port ERR, output, 1 bit: the last load failed its check.

Function
REQ-016 SHALL implement the states IDLE, LOAD, SHIFT, CHECK, DONE and ERROR.
REQ-017 In IDLE, DONE or ERROR, START=1 SHALL go to LOAD next cycle, clear CFG_VALID, ERR, the bit counter and the CRC.
REQ-018 In LOAD, BYTE_READY SHALL be 1; a transfer occurs when BYTE_VALID&BYTE_READY, latching BYTE_IN into an 8-bit shift register and going to SHIFT.
REQ-019 In SHIFT, each cycle SHALL drive CFG_BIT=shreg[7], assert SHIFT_EN, shift shreg left by 1 and increment the bit counter.
REQ-020 SHIFT SHALL shift min(8, CFG_BITS-count) bits; the unused LSBs of a final partial byte are discarded.
REQ-021 After the byte's last bit: count<CFG_BITS SHALL return to LOAD; count==CFG_BITS SHALL go to CHECK.
REQ-022 Throughput SHALL be 1 byte per 9 cycles (1 LOAD plus 8 SHIFT) when BYTE_VALID is held high; a full 80-bit load takes 90 cycles from the first LOAD.
REQ-023 BYTE_READY and SHIFT_EN SHALL be 0 outside LOAD and SHIFT respectively; CFG_BIT SHALL be 0 when SHIFT_EN=0.
REQ-024 BUSY SHALL be 1 in LOAD, SHIFT and CHECK, and 0 otherwise.
REQ-025 DONE SHALL hold CFG_VALID=1 until reset or the next START; ERROR SHALL hold ERR=1 the same way.
REQ-026 START while BUSY SHALL be ignored, with no restart and no error.
REQ-027 BYTE_VALID outside LOAD SHALL be ignored; the byte is not consumed.
REQ-028 The bit counter SHALL be wide enough to hold CFG_BITS without wrap; it never exceeds CFG_BITS.

Reset
REQ-029 RES_N=0 SHALL immediately force IDLE and clear the shift register, counter and CRC.
REQ-030 RES_N=0 SHALL force BYTE_READY, CFG_BIT, SHIFT_EN, BUSY, CFG_VALID and ERR to 0, including mid-load; a partial load leaves CFG_VALID=0.

Configuration
REQ-031 The macro PAL_CFG_CRC_EN SHALL enable CRC checking.
REQ-032 With PAL_CFG_CRC_EN defined, a CRC-8 (polynomial 0x07, init 0x00, MSB-first, no final XOR) SHALL be updated on every shifted bit.
REQ-033 With PAL_CFG_CRC_EN defined, CHECK SHALL assert BYTE_READY and accept one trailer byte; a match goes to DONE, a mismatch goes to ERROR.
REQ-034 Without PAL_CFG_CRC_EN, CHECK SHALL last exactly one cycle and go to DONE, BYTE_READY SHALL be 0 in CHECK, ERR SHALL be tied to 0, and no CRC logic is built.

Verification
REQ-035 Reset, then START with 10 bytes 0xA5 and BYTE_VALID held high (no CRC) -> 80 SHIFT_EN pulses, CFG_BIT pattern 1010_0101 repeated, CFG_VALID=1 at cycle 91 after START.
REQ-036 CFG_BITS=12, bytes 0xFF then 0xF0 -> exactly 12 SHIFT_EN pulses, all CFG_BIT=1, the low nibble of 0xF0 never driven.
REQ-037 BYTE_VALID deasserted for 5 cycles between bytes 3 and 4 -> SHIFT_EN gap of 5 extra cycles, stream otherwise identical.
REQ-038 RES_N pulsed low during byte 6 -> all outputs 0 asynchronously, IDLE; a following START reloads from bit 0.
REQ-039 With PAL_CFG_CRC_EN, 10 bytes 0x00 plus trailer 0x00 -> CFG_VALID=1; the same stream with trailer 0x01 -> ERR=1, CFG_VALID=0.
REQ-040 START pulsed during SHIFT -> ignored, counter unaffected; START in DONE -> CFG_VALID drops next cycle and a new load begins.
